inlier_count_sequencer: RTL

//  Initiator side of the check_inlier handshake. Walks a point-cloud RAM for one plane hypothesis.

---
 rtl/inlier_count_sequencer_if.sv | 33 +++
 rtl/inlier_count_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/inlier_count_sequencer_if.sv
// Point-RAM read port and check_inlier handshake bundle.
// The master side is the sequencer; the slave side is the RAM plus check_inlier.
interface inlier_count_sequencer_if #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 20
);
   logic                    mem_ren;
   logic [ADDR_WIDTH-1:0]   mem_raddr;
   logic [3*WORD_WIDTH-1:0] mem_rdata;
   logic                    chk_ivalid;
   logic                    chk_iready;
   logic [3*WORD_WIDTH-1:0] chk_n;
   logic [3*WORD_WIDTH-1:0] chk_p;
   logic [WORD_WIDTH-1:0]   chk_d;
   logic [WORD_WIDTH-1:0]   chk_t;
   logic                    chk_ovalid;
   logic                    chk_oacknowledge;
   logic                    chk_inlier;

   modport master (
      output mem_ren, mem_raddr,
      input  mem_rdata,
      output chk_ivalid, chk_n, chk_p, chk_d, chk_t, chk_oacknowledge,
      input  chk_iready, chk_ovalid, chk_inlier
   );

   modport slave (
      input  mem_ren, mem_raddr,
      output mem_rdata,
      input  chk_ivalid, chk_n, chk_p, chk_d, chk_t, chk_oacknowledge,
      output chk_iready, chk_ovalid, chk_inlier
   );
endinterface

// File: rtl/inlier_count_sequencer.sv
// Walks the point RAM for one plane hypothesis, feeds each point to check_inlier
// one at a time and reports the number of inliers found.
module inlier_count_sequencer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 20
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_WIDTH:0]     point_count,
   input  logic [3*WORD_WIDTH-1:0] plane_n,
   input  logic [WORD_WIDTH-1:0]   plane_d,
   input  logic [WORD_WIDTH-1:0]   threshold,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_WIDTH:0]     inlier_total,
   inlier_count_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      ISSUE,
      COLLECT,
      DONE
   } state_t;

   state_t state, state_next;

   logic [ADDR_WIDTH:0]     count_q;
   logic [ADDR_WIDTH:0]     index_q;
   logic [ADDR_WIDTH:0]     running_q;
   logic [ADDR_WIDTH:0]     total_q;
   logic [3*WORD_WIDTH-1:0] n_q;
   logic [3*WORD_WIDTH-1:0] p_q;
   logic [WORD_WIDTH-1:0]   d_q;
   logic [WORD_WIDTH-1:0]   t_q;

   logic [ADDR_WIDTH:0]     index_inc;
   logic [ADDR_WIDTH:0]     running_inc;
   logic                    last_point;

   assign index_inc   = index_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign running_inc = running_q + {{ADDR_WIDTH{1'b0}}, bus.chk_inlier};
   assign last_point  = (index_inc == count_q);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start && !abort) state_next = (point_count == '0) ? DONE : FETCH;
         FETCH:    state_next = WAIT_MEM;
         WAIT_MEM: state_next = ISSUE;
         ISSUE:    if (bus.chk_iready) state_next = COLLECT;
         COLLECT:  if (bus.chk_ovalid) state_next = last_point ? DONE : FETCH;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      // abort overrides every transition out of a non-idle state, including a pending result
      if (abort && (state != IDLE)) state_next = IDLE;
   end

   always_comb begin
      busy                 = 1'b0;
      done                 = 1'b0;
      bus.mem_ren          = 1'b0;
      bus.chk_ivalid       = 1'b0;
      bus.chk_oacknowledge = 1'b0;
      case (state)
         FETCH: begin
            busy        = 1'b1;
            bus.mem_ren = 1'b1;
         end
         WAIT_MEM: busy = 1'b1;
         ISSUE: begin
            busy           = 1'b1;
            bus.chk_ivalid = 1'b1;
         end
         COLLECT: begin
            busy                 = 1'b1;
            bus.chk_oacknowledge = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // total is written on entry to DONE so it is already valid while done is high
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q   <= '0;
         index_q   <= '0;
         running_q <= '0;
         total_q   <= '0;
         n_q       <= '0;
         p_q       <= '0;
         d_q       <= '0;
         t_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  n_q       <= plane_n;
                  d_q       <= plane_d;
                  t_q       <= threshold;
                  count_q   <= point_count;
                  running_q <= '0;
                  index_q   <= '0;
                  if (point_count == '0) total_q <= '0;
               end
            end
            WAIT_MEM: begin
               if (!abort) p_q <= bus.mem_rdata;
            end
            COLLECT: begin
               if (!abort && bus.chk_ovalid) begin
                  running_q <= running_inc;
                  index_q   <= index_inc;
                  if (last_point) total_q <= running_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign inlier_total  = total_q;
   assign bus.mem_raddr = index_q[ADDR_WIDTH-1:0];
   assign bus.chk_n     = n_q;
   assign bus.chk_p     = p_q;
   assign bus.chk_d     = d_q;
   assign bus.chk_t     = t_q;

endmodule
